// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame geometry,
// well-known command/response bytes and the frame bit selector.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK_WAIT,
    RELEASE
  } ps2_tx_state_t;

  // Data byte, odd parity and stop bit; the start bit is driven before clocking.
  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] CODE_BREAK   = 8'hF0;

  // Bit of the host-to-device frame driven after device clock edge idx+1.
  function automatic logic frame_bit(input logic [7:0] data, input logic parity,
                                     input logic [3:0] idx);
    logic b;
    b = 1'b1;
    if (idx < 4'd8) b = data[idx[2:0]];
    else if (idx == 4'd8) b = parity;
    return b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one raw PS/2 line plus falling-edge detect.
// Shared by the host transmitter and the receiver.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta_q, cur_q, prev_q;

  // Idle PS/2 lines are pulled high, so the pipeline resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      cur_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
      meta_q <= line;
      cur_q  <= meta_q;
      prev_q <= cur_q;
    end
  end

  assign level = cur_q;
  assign fall  = prev_q & ~cur_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, clocked frame, ACK).
// Define PS2_TX_TIMEOUT_EN to add a per-edge watchdog; otherwise the block waits indefinitely.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [3:0]       STOP_IDX = 4'(FRAME_BITS - 1);

`ifdef PS2_TX_TIMEOUT_EN
  // 64-bit product: the default TIMEOUT_US * CLK_FREQ_HZ exceeds 32 bits.
  localparam longint TIMEOUT_CYCLES = longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / 64'sd1000000;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`endif

  ps2_tx_state_t    state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_smp_q, ack_smp_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk   (CLK),
    .rst_n (reset),
    .line  (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk   (CLK),
    .rst_n (reset),
    .line  (ps2_data_in),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    inh_d     = inh_q;
    idx_d     = idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    ack_smp_d = ack_smp_q;
    done_d    = 1'b0;
    ack_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d      = '0;
    to_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          data_d    = tx_data;
          parity_d  = ~^tx_data;
          inh_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INH_LAST == '0);
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          inh_d     = inh_q + 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = (inh_d == INH_LAST);
        end
      end
      START: begin
        data_oe_d = 1'b1;
        idx_d     = '0;
        state_d   = BITS;
      end
      BITS: begin
        if (clk_fall) begin
          if (idx_q == STOP_IDX) begin
            data_oe_d = 1'b0;
            state_d   = ACK_WAIT;
          end else begin
            data_oe_d = ~frame_bit(data_q, parity_q, idx_q);
            idx_d     = idx_q + 1'b1;
          end
        end
      end
      ACK_WAIT: begin
        data_oe_d = 1'b0;
        if (clk_fall) begin
          ack_smp_d = ~data_level;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        data_oe_d = 1'b0;
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          ack_d   = ack_smp_q;
          state_d = IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // A device edge always wins over an expiring watchdog in the same cycle.
    if (state_q == BITS || state_q == ACK_WAIT) begin
      if (clk_fall) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        ack_d     = 1'b0;
        to_d      = 1'b1;
        state_d   = IDLE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      inh_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_smp_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_smp_q <= ack_smp_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= wd_d;
      to_q      <= to_d;
`endif
    end
  end

  // Line enables come straight from flops so the open-drain pins never glitch.
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ack_ok      = ack_q;
`ifdef PS2_TX_TIMEOUT_EN
  assign timeout     = to_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: behavioural PS/2 device model, frame
// expectations derived from the byte, inhibit timing, NACK, stall/watchdog, reset abort.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_FREQ_HZ    = 16000000;
  localparam int INHIBIT_US     = 100;
  localparam int TIMEOUT_US     = 400;
  localparam int INHIBIT_CYCLES = INHIBIT_US * (CLK_FREQ_HZ / 1000000);
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = TIMEOUT_US * (CLK_FREQ_HZ / 1000000);
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 CLK = ~CLK;

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .INHIBIT_US  (INHIBIT_US),
    .TIMEOUT_US  (TIMEOUT_US)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .timeout     (timeout)
  );

  always @(posedge CLK) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame as the device should see it: data LSB first, odd parity, stop.
  function automatic logic [9:0] expected_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = (b >> i) & 8'h01;
      ones += int'((b >> i) & 8'h01);
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Raise a request, then measure the inhibit window and request-to-send.
  task automatic send_request(input logic [7:0] b);
    int k, hi_cnt, both;
    logic last_doe;
    tx_data  = b;
    tx_valid = 1'b1;
    k = 0;
    while (tx_ready !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check($sformatf("ready_before_accept_%02h", b), tx_ready, 1);
    @(negedge CLK);
    tx_data = ~b;
    check($sformatf("busy_after_accept_%02h", b), busy, 1);
    check($sformatf("not_ready_after_accept_%02h", b), tx_ready, 0);
    hi_cnt = 0;
    both = 0;
    last_doe = 1'b0;
    k = 0;
    while (ps2_clk_oe === 1'b1 && k < 4 * INHIBIT_CYCLES) begin
      hi_cnt++;
      if (ps2_data_oe === 1'b1) both++;
      last_doe = ps2_data_oe;
      if (k == 2) tx_valid = 1'b0;
      @(negedge CLK);
      k++;
    end
    tx_valid = 1'b0;
    check($sformatf("inhibit_len_%02h", b), hi_cnt, INHIBIT_CYCLES);
    check($sformatf("data_oe_in_inhibit_%02h", b), both, 1);
    check($sformatf("data_oe_before_release_%02h", b), last_doe, 1);
    check($sformatf("start_clk_released_%02h", b), ps2_clk_oe, 0);
    check($sformatf("start_data_low_%02h", b), ps2_data_oe, 1);
  endtask

  // Device model: n clocks, samples each host bit on the rising edge.
  task automatic device_clock(input int n, input logic ack_low, input logic abort_mid,
                              input logic [7:0] b);
    logic [9:0] f;
    int lo, hi;
    f  = expected_frame(b);
    lo = $urandom_range(15, 30);
    hi = $urandom_range(15, 30);
    repeat (10) @(negedge CLK);
    for (int i = 0; i < n; i++) begin
      dev_clk_low = 1'b1;
      repeat (lo) @(negedge CLK);
      if (abort_mid && i == n - 1) begin
        check($sformatf("bit%0d_before_reset_%02h", i, b), ps2_data_in, f[i]);
        return;
      end
      dev_clk_low = 1'b0;
      if (i < FRAME_BITS) check($sformatf("frame_bit%0d_%02h", i, b), ps2_data_in, f[i]);
      if (i == FRAME_BITS - 1 && ack_low) dev_data_low = 1'b1;
      if (i < n - 1) repeat (hi) @(negedge CLK);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input logic exp_ack, input logic b2b, input logic [7:0] nxt,
                           input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_ack_ok"}, ack_ok, exp_ack);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_ready_with_done"}, tx_ready, 1);
    check({tag, "_clk_oe_idle"}, ps2_clk_oe, 0);
    check({tag, "_data_oe_idle"}, ps2_data_oe, 0);
    if (b2b) begin
      tx_data  = nxt;
      tx_valid = 1'b1;
    end else begin
      @(negedge CLK);
      check({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  initial begin
    int saved, n;
    logic [7:0] rb;
    logic ra;

    repeat (3) @(negedge CLK);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_ok", ack_ok, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b1;
    @(negedge CLK);

    // Set-LEDs command, acknowledged.
    send_request(CMD_SET_LEDS);
    device_clock(11, 1'b1, 1'b0, CMD_SET_LEDS);
    wait_done(1'b1, 1'b0, 8'h00, "ed");

    // Parity corners, second request accepted in the done cycle.
    send_request(8'h01);
    device_clock(11, 1'b1, 1'b0, 8'h01);
    wait_done(1'b1, 1'b1, 8'h00, "b01");
    send_request(8'h00);
    device_clock(11, 1'b1, 1'b0, 8'h00);
    wait_done(1'b1, 1'b0, 8'h00, "b00");

    // Device leaves data high on the 11th clock.
    send_request(8'hA5);
    device_clock(11, 1'b0, 1'b0, 8'hA5);
    wait_done(1'b0, 1'b0, 8'h00, "nack");

    // Device never clocks.
    send_request(8'h3C);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < TIMEOUT_CYCLES + 100) begin
      @(negedge CLK);
      n++;
    end
    check("wd_done", done, 1);
    check("wd_gap_window", (n >= TIMEOUT_CYCLES + 1) && (n <= TIMEOUT_CYCLES + 4), 1);
    check("wd_timeout", timeout, 1);
    check("wd_ack_ok", ack_ok, 0);
    check("wd_clk_oe", ps2_clk_oe, 0);
    check("wd_data_oe", ps2_data_oe, 0);
    check("wd_ready", tx_ready, 1);
    @(negedge CLK);
    check("wd_done_one_cycle", done, 0);
`else
    saved = done_cnt;
    repeat (10000) @(negedge CLK);
    check("stall_busy", busy, 1);
    check("stall_no_done", done_cnt, saved);
    check("stall_timeout", timeout, 0);
    check("stall_start_held", ps2_data_oe, 1);
    device_clock(11, 1'b1, 1'b0, 8'h3C);
    wait_done(1'b1, 1'b0, 8'h00, "stall");
`endif

    // Reset during the 4th data bit.
    send_request(8'hC3);
    device_clock(4, 1'b1, 1'b1, 8'hC3);
    saved = done_cnt;
    reset = 1'b0;
    @(negedge CLK);
    check("abort_clk_oe", ps2_clk_oe, 0);
    check("abort_data_oe", ps2_data_oe, 0);
    check("abort_ready", tx_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b1;
    dev_clk_low = 1'b0;
    repeat (200) @(negedge CLK);
    check("abort_no_done", done_cnt, saved);
    check("abort_idle_clk_oe", ps2_clk_oe, 0);
    send_request(8'hF4);
    device_clock(11, 1'b1, 1'b0, 8'hF4);
    wait_done(1'b1, 1'b0, 8'h00, "f4");

    // Random bytes with random ACK/NACK.
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      send_request(rb);
      device_clock(11, ra, 1'b0, rb);
      wait_done(ra, 1'b0, 8'h00, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_time_limit: observed run still active expected finished");
    $fatal(1, "time limit");
  end

endmodule
